// File: rtl/prbs7_xnor_checker.sv
// Serial PRBS-7 (x^7+x^6+1, XNOR form) checker: seeds, verifies and locks a local LFSR, counts errors.
// Optional BIT_CNT output and counter are built when PRBS_CHK_BITCNT_EN is defined.
module prbs7_xnor_checker #(
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             DIN,
    input  logic             CLR_CNT,
    output logic             LOCKED,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [CNT_W-1:0] BIT_CNT
`endif
);

    localparam int unsigned SEED_W = 3;
    localparam int unsigned RUN_W  = 8;
    localparam int unsigned LOSS_W = 4;

    typedef enum logic [1:0] {
        ST_SEED,
        ST_VERIFY,
        ST_LOCKED
    } state_e;

    state_e              state_q, state_d;
    logic [6:0]          s_q, s_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
`ifdef PRBS_CHK_BITCNT_EN
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
`endif

    logic                pred;
    logic                match;
    logic [6:0]          s_din;
    logic [RUN_W-1:0]    run_inc;
    logic [LOSS_W-1:0]   loss_inc;

    // Next-state and counter logic; every transition is gated by EN
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        seed_d    = seed_q;
        run_d     = run_q;
        loss_d    = loss_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
`ifdef PRBS_CHK_BITCNT_EN
        bit_cnt_d = bit_cnt_q;
`endif
        pred      = ~(s_q[6] ^ s_q[5]);
        match     = ~(pred ^ DIN);
        s_din     = {s_q[5:0], DIN};
        run_inc   = run_q + RUN_W'(1);
        loss_inc  = loss_q + LOSS_W'(1);

        if (EN) begin
            unique case (state_q)
                ST_SEED: begin
                    s_d = s_din;
                    if (seed_q == SEED_W'(6)) begin
                        state_d = ST_VERIFY;
                        seed_d  = '0;
                        run_d   = '0;
                    end else begin
                        seed_d = seed_q + SEED_W'(1);
                    end
                end
                ST_VERIFY: begin
                    s_d   = s_din;
                    run_d = match ? run_inc : '0;
                    // All-ones is the XNOR lockup state and can never be a valid seed
                    if (&s_din) begin
                        state_d = ST_SEED;
                        seed_d  = '0;
                        run_d   = '0;
                    end else if (match && (run_inc == RUN_W'(LOCK_CNT))) begin
                        state_d = ST_LOCKED;
                        loss_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    // Free-running prediction so a bad bit never corrupts later predictions
                    s_d = {s_q[5:0], pred};
`ifdef PRBS_CHK_BITCNT_EN
                    if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
`endif
                    if (!match) begin
                        err_d  = 1'b1;
                        loss_d = loss_inc;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                        if (loss_inc == LOSS_W'(LOSS_CNT)) begin
                            state_d = ST_SEED;
                            seed_d  = '0;
                        end
                    end else begin
                        loss_d = '0;
                    end
                end
                default: state_d = ST_SEED;
            endcase
        end

        if (CLR_CNT) begin
            err_cnt_d = '0;
`ifdef PRBS_CHK_BITCNT_EN
            bit_cnt_d = '0;
`endif
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_SEED;
            s_q       <= '0;
            seed_q    <= '0;
            run_q     <= '0;
            loss_q    <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
`ifdef PRBS_CHK_BITCNT_EN
            bit_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            seed_q    <= seed_d;
            run_q     <= run_d;
            loss_q    <= loss_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
`ifdef PRBS_CHK_BITCNT_EN
            bit_cnt_q <= bit_cnt_d;
`endif
        end
    end

    assign LOCKED  = locked_q;
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;
`ifdef PRBS_CHK_BITCNT_EN
    assign BIT_CNT = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Bench for prbs7_xnor_checker: directed phases plus random traffic against a queue-based stream model.
// A second instance with CNT_W=4 shares all inputs to exercise counter saturation.
module tb_prbs7_xnor_checker;

    localparam int LOCK_N = 16;
    localparam int LOSS_N = 4;

    logic        clk = 1'b0;
    logic        rst_n, en, din, clr;
    logic        locked, err, locked4, err4;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt4;
`ifdef PRBS_CHK_BITCNT_EN
    logic [15:0] bit_cnt;
    logic [3:0]  bit_cnt4;
`endif

    always #5 clk = ~clk;

    prbs7_xnor_checker u_dut (
        .CLK(clk), .RST_N(rst_n), .EN(en), .DIN(din), .CLR_CNT(clr),
        .LOCKED(locked), .ERR(err), .ERR_CNT(err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
        , .BIT_CNT(bit_cnt)
`endif
    );

    prbs7_xnor_checker #(.CNT_W(4)) u_dut_w4 (
        .CLK(clk), .RST_N(rst_n), .EN(en), .DIN(din), .CLR_CNT(clr),
        .LOCKED(locked4), .ERR(err4), .ERR_CNT(err_cnt4)
`ifdef PRBS_CHK_BITCNT_EN
        , .BIT_CNT(bit_cnt4)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: window of the last 7 reference bits, oldest first
    int   m_mode;      // 0 seed, 1 verify, 2 locked
    logic m_win[$];
    int   m_seeded, m_run, m_row, m_raw_err, m_raw_bits;
    logic m_err;
    logic [6:0] g_q;   // reference stream generator

    task automatic next_ref(output logic b);
        b   = ~(g_q[6] ^ g_q[5]);
        g_q = {g_q[5:0], b};
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic d, input logic c);
        logic p, hit;
        int   ones;
        if (!r) begin
            m_mode = 0; m_seeded = 0; m_run = 0; m_row = 0;
            m_raw_err = 0; m_raw_bits = 0; m_err = 1'b0;
            m_win = {};
            repeat (7) m_win.push_back(1'b0);
        end else begin
            m_err = 1'b0;
            p     = ~(m_win[0] ^ m_win[1]);
            hit   = (p == d);
            if (e) begin
                if (m_mode == 0) begin
                    m_win.push_back(d); void'(m_win.pop_front());
                    m_seeded++;
                    if (m_seeded == 7) begin m_mode = 1; m_run = 0; m_seeded = 0; end
                end else if (m_mode == 1) begin
                    m_win.push_back(d); void'(m_win.pop_front());
                    m_run = hit ? m_run + 1 : 0;
                    ones = 0;
                    foreach (m_win[i]) ones += m_win[i] ? 1 : 0;
                    if (ones == 7) begin m_mode = 0; m_seeded = 0; m_run = 0; end
                    else if (m_run == LOCK_N) begin m_mode = 2; m_row = 0; end
                end else begin
                    m_win.push_back(p); void'(m_win.pop_front());
                    m_raw_bits++;
                    if (!hit) begin
                        m_err = 1'b1; m_raw_err++; m_row++;
                        if (m_row == LOSS_N) begin m_mode = 0; m_seeded = 0; end
                    end else begin
                        m_row = 0;
                    end
                end
            end
            if (c) begin m_raw_err = 0; m_raw_bits = 0; end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, let the edge consume, update the model, compare 1 ns later
    task automatic step(input logic e, input logic d, input logic c);
        en = e; din = d; clr = c;
        @(posedge clk);
        model_edge(rst_n, e, d, c);
        #1;
        check("locked",   32'(locked),   32'(m_mode == 2));
        check("err",      32'(err),      32'(m_err));
        check("err_cnt",  32'(err_cnt),  32'(sat(m_raw_err, 16)));
        check("locked4",  32'(locked4),  32'(m_mode == 2));
        check("err4",     32'(err4),     32'(m_err));
        check("err_cnt4", 32'(err_cnt4), 32'(sat(m_raw_err, 4)));
`ifdef PRBS_CHK_BITCNT_EN
        check("bit_cnt",  32'(bit_cnt),  32'(sat(m_raw_bits, 16)));
        check("bit_cnt4", 32'(bit_cnt4), 32'(sat(m_raw_bits, 4)));
`endif
    endtask

    initial begin
        logic b, e, f;
        int   first_lock, pulses, w, maxw, consumed, any_lock;

        rst_n = 1'b0; en = 1'b0; din = 1'b0; clr = 1'b0; g_q = '0;
        step(0, 0, 0);
        step(0, 0, 0);
        check("rst_locked",  32'(locked),  32'(0));
        check("rst_err_cnt", 32'(err_cnt), 32'(0));
        rst_n = 1'b1;

        // Clean stream: lock after 7 seed + 16 verify bits
        first_lock = -1;
        for (int i = 1; i <= 1000; i++) begin
            next_ref(b);
            step(1, b, 0);
            if (locked === 1'b1 && first_lock < 0) first_lock = i;
        end
        check("lock_cycle",   32'(first_lock), 32'(23));
        check("clean_errcnt", 32'(err_cnt),    32'(0));
`ifdef PRBS_CHK_BITCNT_EN
        check("clean_bitcnt",  32'(bit_cnt),  32'(977));
        check("clean_bitcnt4", 32'(bit_cnt4), 32'(15));
`endif

        // Three isolated bit errors
        next_ref(b); step(1, b, 1);
        pulses = 0; w = 0; maxw = 0;
        for (int i = 0; i < 60; i++) begin
            next_ref(b);
            step(1, b ^ (i % 20 == 10), 0);
            if (err === 1'b1) begin pulses++; w++; end else w = 0;
            if (w > maxw) maxw = w;
        end
        check("single_pulses", 32'(pulses),  32'(3));
        check("single_width",  32'(maxw),    32'(1));
        check("single_errcnt", 32'(err_cnt), 32'(3));
        check("single_locked", 32'(locked),  32'(1));

        // Four consecutive errors drop lock, clean stream relocks
        next_ref(b); step(1, b, 1);
        for (int k = 0; k < 4; k++) begin
            next_ref(b);
            step(1, ~b, 0);
            if (k == 2) check("loss_hold", 32'(locked), 32'(1));
        end
        check("loss_fall",   32'(locked),  32'(0));
        check("loss_err",    32'(err),     32'(1));
        check("loss_errcnt", 32'(err_cnt), 32'(4));
        first_lock = -1;
        for (int i = 1; i <= 30; i++) begin
            next_ref(b);
            step(1, b, 0);
            if (locked === 1'b1 && first_lock < 0) first_lock = i;
        end
        check("relock_bits",   32'(first_lock), 32'(23));
        check("relock_errcnt", 32'(err_cnt),    32'(4));

        // Lockup seed: ones then noise must never lock
        rst_n = 1'b0; step(0, 0, 0); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 1, 0);
        any_lock = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 1'($urandom % 2), 0);
            if (locked !== 1'b0) any_lock = 1;
        end
        check("lockup_nolock", 32'(any_lock), 32'(0));
        for (int i = 0; i < 60; i++) begin
            next_ref(b);
            step(1, b, 0);
        end
        check("lockup_relock", 32'(locked), 32'(1));

        // EN gaps 1-0-0-1 are transparent
        rst_n = 1'b0; step(0, 0, 0); rst_n = 1'b1;
        g_q = '0; consumed = 0; first_lock = -1;
        for (int i = 0; i < 200 && consumed < 40; i++) begin
            e = (i % 4 == 0) || (i % 4 == 3);
            if (e) next_ref(b); else b = 1'($urandom % 2);
            step(e, b, 0);
            if (e) consumed++;
            if (locked === 1'b1 && first_lock < 0) first_lock = consumed;
        end
        check("gap_lock_bits", 32'(first_lock), 32'(23));
        next_ref(b); step(1, ~b, 1);
        check("clr_vs_err_cnt", 32'(err_cnt), 32'(0));
        check("clr_vs_err_err", 32'(err),     32'(1));

        // Saturation with 20 isolated errors, then a one-cycle reset while locked
        next_ref(b); step(1, b, 1);
        for (int k = 0; k < 20; k++) begin
            next_ref(b); step(1, ~b, 0);
            next_ref(b); step(1, b, 0);
        end
        check("sat_errcnt4",  32'(err_cnt4), 32'(15));
        check("sat_errcnt16", 32'(err_cnt),  32'(20));
        check("sat_locked",   32'(locked),   32'(1));
        rst_n = 1'b0; next_ref(b); step(1, b, 0); rst_n = 1'b1;
        check("rst_lock_locked", 32'(locked),  32'(0));
        check("rst_lock_errcnt", 32'(err_cnt), 32'(0));

        // Random EN, errors and clears against the model
        for (int i = 0; i < 600; i++) begin
            e = ($urandom % 4) != 0;
            f = ($urandom % 32) == 0;
            if (e) begin next_ref(b); b = b ^ f; end else b = 1'($urandom % 2);
            step(e, b, 1'(($urandom % 64) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs7_xnor_checker.md
# prbs7_xnor_checker

- Serial PRBS-7 checker; consumes the 1-bit stream from the XNOR-feedback PRBS-7 generator on the link under test.
- Aligns a local XNOR LFSR to the incoming stream and compares every valid bit against its prediction with an XNOR match term.
- Reports lock status, a per-bit error pulse and a saturating error count.
- Sits at the receive end of the gate-level test path and is the first sequential consumer of the XNOR primitive.

## Interface
Parameters:
- LOCK_CNT, 16: consecutive matches in VERIFY needed to declare lock (range 1..255).
- LOSS_CNT, 4: consecutive errors in LOCKED that drop lock (range 1..15).
- CNT_W, 16: width of ERR_CNT and BIT_CNT.

Ports:
- CLK, input, 1: single clock; all logic on its rising edge.
- RST_N, input, 1: reset, synchronous, active-low.
- EN, input, 1: DIN valid this cycle; no bit is consumed when low.
- DIN, input, 1: received serial bit.
- CLR_CNT, input, 1: synchronous clear of ERR_CNT and BIT_CNT.
- LOCKED, output, 1: checker is aligned to the stream.
- ERR, output, 1: one-cycle pulse for a mismatching bit while LOCKED.
- ERR_CNT, output, CNT_W: errors counted while LOCKED; saturates at all-ones.
- BIT_CNT, output, CNT_W: bits checked while LOCKED; saturates. Present only with PRBS_CHK_BITCNT_EN.

## Operation
LFSR:
- State s[6:0]; s[0] is the newest bit.
- Predicted next bit p = ~(s[6] ^ s[5]) (polynomial x^7+x^6+1, XNOR form).
- Match m = ~(p ^ DIN).
- All-ones is the lockup state and never occurs in a valid stream.

FSM states are SEED, VERIFY and LOCKED. Nothing in this list changes when EN=0.
- SEED: on each EN, s <= {s[5:0], DIN} and the seed counter increments. After the 7th bit, go to VERIFY with run counter = 0.
- VERIFY: on each EN, s <= {s[5:0], DIN} (self-synchronising).
  - m=1: run counter increments. When it reaches LOCK_CNT, go to LOCKED.
  - m=0: run counter resets to 0 and the FSM stays in VERIFY.
  - If s is all-ones after the shift, return to SEED and restart the seed count.
  - Errors here are not reported and not counted.
- LOCKED: on each EN, s <= {s[5:0], p}. The free-running prediction keeps errors from propagating.
  - m=0: ERR pulses, ERR_CNT increments (saturating) and the consecutive-error counter increments.
  - m=1: consecutive-error counter clears.
  - When the consecutive-error counter reaches LOSS_CNT, go to SEED. ERR_CNT keeps its value.
- Counters:
  - CLR_CNT has priority over an increment in the same cycle; the result is 0.
  - A saturated counter holds at 2^CNT_W-1.
- Reset (RST_N=0 at an edge, from any state, including mid-seed or mid-lock):
  - FSM = SEED; s = 7'h00; seed, run and error-run counters = 0.
  - LOCKED=0, ERR=0, ERR_CNT=0, BIT_CNT=0.

## Timing
- All outputs are registered and update on the edge that consumes the bit.
- ERR is high for exactly the one cycle after a LOCKED mismatch is consumed. It is never high for two cycles from a single bit.
- ERR_CNT reflects the error in the same cycle ERR is high.
- LOCKED rises the cycle after the LOCK_CNT-th consecutive VERIFY match is consumed.
- Minimum time to lock from reset with EN held high: 7 + LOCK_CNT cycles.
- LOCKED falls the cycle after the LOSS_CNT-th consecutive error is consumed. ERR also pulses for that bit.
- EN gaps of any length are transparent: state and counters hold.
- No output combinationally depends on DIN or EN.

## Configuration
- PRBS_CHK_BITCNT_EN defined:
  - The BIT_CNT port and counter exist.
  - BIT_CNT increments on every EN cycle in LOCKED, saturates, and is cleared by CLR_CNT and reset.
- Not defined:
  - The BIT_CNT port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Clean stream: reset, then feed a reference XNOR PRBS-7 stream with EN=1 and default parameters. LOCKED rises at cycle 23 after reset release; ERR_CNT stays 0 over 1000 bits; BIT_CNT equals the locked-cycle count.
- Single errors: once locked, flip 3 isolated bits spaced 20 apart. Exactly 3 ERR pulses, each one cycle wide; ERR_CNT=3; LOCKED stays 1.
- Loss of lock: once locked, invert 4 consecutive bits. ERR_CNT=4; LOCKED falls the cycle after the 4th bit. With a clean stream afterwards, LOCKED returns within 7+16 valid bits and ERR_CNT holds at 4.
- Lockup seed: feed 7 ones followed by noise. The checker returns to SEED and LOCKED stays 0. With a valid stream afterwards, it locks normally.
- EN gaps and clear: lock with EN toggling 1-0-0-1. Results match the EN=1 run bit-for-bit. Assert CLR_CNT in the same cycle as an error: ERR_CNT=0.
- Saturation and reset: use CNT_W=4 and inject 20 errors. ERR_CNT holds at 15. Assert RST_N=0 for one cycle while locked: the next cycle shows LOCKED=0 and ERR_CNT=0.
